// File: rtl/vga_pic_source.sv
// vga_pic_source: VGA raster generator and picture fetcher feeding the Sobel stage.
//
// Generates the raster timing (800x600@60 by default) and reads a picture from an external
// synchronous image ROM. The picture sits at (PIC_X_START, PIC_Y_START), PIC_WIDTH x PIC_HEIGHT.
// Outside that window, and during blanking, BG_COLOR is driven. Every output is registered.
// All outputs are aligned to the same pixel, so the ROM read latency never reaches downstream.
//
// Ports:
//   clk_i          pixel clock
//   rst_i          synchronous reset, active-high
//   rom_addr_o     image ROM address, row-major, 0..PIC_WIDTH*PIC_HEIGHT-1
//   rom_q_i        image ROM data {R,G,B}, valid ROM_LAT cycles after rom_addr_o
//   pixel_x_o      column of the current output pixel
//   pixel_y_o      row of the current output pixel
//   rgb_data_o     colour of (pixel_x_o, pixel_y_o)
//   de_o           data enable, high inside the active area
//   hsync_o        horizontal sync, polarity set by SYNC_POL
//   vsync_o        vertical sync, polarity set by SYNC_POL
//   frame_start_o  one-cycle pulse on output pixel (0,0)
module vga_pic_source #(
    parameter int unsigned H_ACTIVE    = 800,
    parameter int unsigned H_FP        = 40,
    parameter int unsigned H_SYNC      = 128,
    parameter int unsigned H_BP        = 88,
    parameter int unsigned V_ACTIVE    = 600,
    parameter int unsigned V_FP        = 1,
    parameter int unsigned V_SYNC      = 4,
    parameter int unsigned V_BP        = 23,
    parameter logic [10:0] PIC_X_START = 11'd200,
    parameter logic [10:0] PIC_Y_START = 11'd100,
    parameter logic [10:0] PIC_WIDTH   = 11'd200,
    parameter logic [10:0] PIC_HEIGHT  = 11'd200,
    parameter int unsigned ROM_LAT     = 1,
    parameter logic [23:0] BG_COLOR    = 24'h000000,
    parameter logic        SYNC_POL    = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [15:0] rom_addr_o,
    input  logic [23:0] rom_q_i,
    output logic [10:0] pixel_x_o,
    output logic [10:0] pixel_y_o,
    output logic [23:0] rgb_data_o,
    output logic        de_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        frame_start_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Stage-0 values travel ROM_LAT+1 stages, then the output register adds the final cycle.
    localparam int DLY = int'(ROM_LAT) + 1;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [11:0] WIN_X_END = 12'(int'(PIC_X_START) + int'(PIC_WIDTH));
    localparam logic [11:0] WIN_Y_END = 12'(int'(PIC_Y_START) + int'(PIC_HEIGHT));
    localparam logic [15:0] ADDR_LAST = 16'(int'(PIC_WIDTH) * int'(PIC_HEIGHT) - 1);

    typedef struct packed {
        logic        valid;
        logic [10:0] x;
        logic [10:0] y;
        logic        win;
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
    } stage_t;

    logic [10:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic [15:0] rom_addr_q, rom_addr_d;
    stage_t      s0;
    stage_t      pipe_q [DLY];
    stage_t      last;

    logic [10:0] pixel_x_q, pixel_y_q;
    logic [23:0] rgb_q, rgb_d;
    logic        de_q, hsync_q, vsync_q, fs_q;

    // Stage 0: raster counters and per-pixel flags.
    always_comb begin
        h_cnt_d = h_cnt_q + 11'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 11'd1;
        end
    end

    always_comb begin
        s0       = '0;
        s0.valid = 1'b1;
        s0.x     = h_cnt_q;
        s0.y     = v_cnt_q;
        s0.win   = (h_cnt_q >= PIC_X_START) && ({1'b0, h_cnt_q} < WIN_X_END) &&
                   (v_cnt_q >= PIC_Y_START) && ({1'b0, v_cnt_q} < WIN_Y_END);
        s0.de    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        s0.hs    = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
        s0.vs    = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
        s0.fs    = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    // rom_addr_q holds the address of the pixel now in stage 1. It advances past each window
    // pixel, and it saturates on the last one, so it never points beyond the picture.
    always_comb begin
        rom_addr_d = rom_addr_q;
        if (s0.fs) begin
            rom_addr_d = '0;
        end else if (pipe_q[0].win && (rom_addr_q != ADDR_LAST)) begin
            rom_addr_d = rom_addr_q + 16'd1;
        end
    end

    assign last = pipe_q[DLY-1];

    // rom_q_i now belongs to the pixel in the last delay stage.
    always_comb begin
        rgb_d = (last.valid && last.win) ? rom_q_i : BG_COLOR;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            rom_addr_q <= '0;
            for (int i = 0; i < DLY; i++) begin
                pipe_q[i] <= '0;
            end
            pixel_x_q  <= '0;
            pixel_y_q  <= '0;
            rgb_q      <= BG_COLOR;
            de_q       <= 1'b0;
            hsync_q    <= ~SYNC_POL;
            vsync_q    <= ~SYNC_POL;
            fs_q       <= 1'b0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            rom_addr_q <= rom_addr_d;
            pipe_q[0]  <= s0;
            for (int i = 1; i < DLY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            pixel_x_q  <= last.x;
            pixel_y_q  <= last.y;
            rgb_q      <= rgb_d;
            de_q       <= last.valid & last.de;
            hsync_q    <= (last.valid & last.hs) ~^ SYNC_POL;
            vsync_q    <= (last.valid & last.vs) ~^ SYNC_POL;
            fs_q       <= last.valid & last.fs;
        end
    end

    assign rom_addr_o    = rom_addr_q;
    assign pixel_x_o     = pixel_x_q;
    assign pixel_y_o     = pixel_y_q;
    assign rgb_data_o    = rgb_q;
    assign de_o          = de_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign frame_start_o = fs_q;

endmodule

// File: tb/tb_vga_pic_source.sv
// Bench for vga_pic_source: one full-size instance and two shrunken-raster instances.
// The shrunken rasters let whole frames and the picture window fit in a short run.
// One of them uses ROM_LAT=3, active-low syncs and a non-zero background.
module tb_vga_pic_source;

    // Shrunken raster: 25 x 17 = 425 cycles per frame, 5x4 picture at (3,2).
    localparam int SHA = 16, SHF = 2, SHS = 4, SHB = 3;
    localparam int SVA = 12, SVF = 1, SVS = 2, SVB = 2;
    localparam int SPX = 3, SPY = 2, SPW = 5, SPH = 4;
    localparam logic [23:0] BG3 = 24'hA5A5A5;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [23:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [15:0] addr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int t     = 0;
    bit armed = 1'b0;

    // Full-size instance.
    logic [15:0] f_addr;
    logic [23:0] f_q, f_rgb;
    logic [10:0] f_x, f_y;
    logic        f_de, f_hs, f_vs, f_fs;

    vga_pic_source u_full (
        .clk_i(clk), .rst_i(rst), .rom_addr_o(f_addr), .rom_q_i(f_q),
        .pixel_x_o(f_x), .pixel_y_o(f_y), .rgb_data_o(f_rgb), .de_o(f_de),
        .hsync_o(f_hs), .vsync_o(f_vs), .frame_start_o(f_fs)
    );

    // Shrunken raster, ROM_LAT=1.
    logic [15:0] s1_addr;
    logic [23:0] s1_q, s1_rgb;
    logic [10:0] s1_x, s1_y;
    logic        s1_de, s1_hs, s1_vs, s1_fs;

    vga_pic_source #(
        .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
        .PIC_X_START(11'(SPX)), .PIC_Y_START(11'(SPY)),
        .PIC_WIDTH(11'(SPW)), .PIC_HEIGHT(11'(SPH)),
        .ROM_LAT(1), .BG_COLOR(24'h000000), .SYNC_POL(1'b1)
    ) u_s1 (
        .clk_i(clk), .rst_i(rst), .rom_addr_o(s1_addr), .rom_q_i(s1_q),
        .pixel_x_o(s1_x), .pixel_y_o(s1_y), .rgb_data_o(s1_rgb), .de_o(s1_de),
        .hsync_o(s1_hs), .vsync_o(s1_vs), .frame_start_o(s1_fs)
    );

    // Shrunken raster, ROM_LAT=3, active-low syncs.
    logic [15:0] s3_addr;
    logic [23:0] s3_q, s3_rgb;
    logic [10:0] s3_x, s3_y;
    logic        s3_de, s3_hs, s3_vs, s3_fs;

    vga_pic_source #(
        .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
        .PIC_X_START(11'(SPX)), .PIC_Y_START(11'(SPY)),
        .PIC_WIDTH(11'(SPW)), .PIC_HEIGHT(11'(SPH)),
        .ROM_LAT(3), .BG_COLOR(BG3), .SYNC_POL(1'b0)
    ) u_s3 (
        .clk_i(clk), .rst_i(rst), .rom_addr_o(s3_addr), .rom_q_i(s3_q),
        .pixel_x_o(s3_x), .pixel_y_o(s3_y), .rgb_data_o(s3_rgb), .de_o(s3_de),
        .hsync_o(s3_hs), .vsync_o(s3_vs), .frame_start_o(s3_fs)
    );

    // ROM models: q = address, zero-extended, after the instance's latency.
    logic [23:0] s3_p1, s3_p2;
    always @(posedge clk) begin
        f_q   <= {8'h00, f_addr};
        s1_q  <= {8'h00, s1_addr};
        s3_p1 <= {8'h00, s3_addr};
        s3_p2 <= s3_p1;
        s3_q  <= s3_p2;
    end

    // t = cycles since the last clock edge that saw reset.
    always @(posedge clk) begin
        if (rst) begin
            t     <= 0;
            armed <= 1'b1;
        end else begin
            t <= t + 1;
        end
    end

    // Reference: output t cycles after reset is raster index t-L. rom_addr at t is the count of
    // window pixels ahead of raster index t-1, capped at the last picture address.
    function automatic exp_t model(input int tt, input int lat,
                                   input int ha, input int hf, input int hsy, input int hb,
                                   input int va, input int vf, input int vsy, input int vb,
                                   input int px, input int py, input int pw, input int ph,
                                   input logic [23:0] bg, input logic pol);
        exp_t e;
        int ht, vt, fr, l, k, h, v, a, n, c;
        ht = ha + hf + hsy + hb;
        vt = va + vf + vsy + vb;
        fr = ht * vt;
        l  = lat + 2;
        n  = pw * ph;
        e.x = '0; e.y = '0; e.rgb = bg; e.de = 1'b0;
        e.hs = ~pol; e.vs = ~pol; e.fs = 1'b0;
        if (tt >= l) begin
            k = (tt - l) % fr;
            h = k % ht;
            v = k / ht;
            e.x  = 11'(h);
            e.y  = 11'(v);
            e.de = (h < ha) && (v < va);
            e.hs = (h >= ha + hf && h < ha + hf + hsy) ? pol : ~pol;
            e.vs = (v >= va + vf && v < va + vf + vsy) ? pol : ~pol;
            e.fs = (k == 0);
            if (h >= px && h < px + pw && v >= py && v < py + ph)
                e.rgb = 24'((v - py) * pw + (h - px));
        end
        if (tt == 0) begin
            a = 0;
        end else begin
            k = (tt - 1) % fr;
            h = k % ht;
            v = k / ht;
            if (v < py) begin
                a = 0;
            end else if (v >= py + ph) begin
                a = n;
            end else begin
                c = h - px;
                if (c < 0) c = 0;
                if (c > pw) c = pw;
                a = (v - py) * pw + c;
            end
            if (a > n - 1) a = n - 1;
        end
        e.addr = 16'(a);
        return e;
    endfunction

    task automatic cmp(input string nm, input int tt, input exp_t g, input exp_t e);
        n_chk++;
        if (g !== e) begin
            n_err++;
            $display("FAIL %s t=%0d got x=%0d y=%0d rgb=%h de=%b hs=%b vs=%b fs=%b addr=%0d | want x=%0d y=%0d rgb=%h de=%b hs=%b vs=%b fs=%b addr=%0d",
                     nm, tt, g.x, g.y, g.rgb, g.de, g.hs, g.vs, g.fs, g.addr,
                     e.x, e.y, e.rgb, e.de, e.hs, e.vs, e.fs, e.addr);
        end
    endtask

    task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    int s1_last_fs = -1;
    int f_hcnt     = 0;
    int pins       = 0;

    always @(negedge clk) begin
        if (armed) begin
            cmp("full", t, {f_x, f_y, f_rgb, f_de, f_hs, f_vs, f_fs, f_addr},
                model(t, 1, 800, 40, 128, 88, 600, 1, 4, 23, 200, 100, 200, 200, 24'h0, 1'b1));
            cmp("s1", t, {s1_x, s1_y, s1_rgb, s1_de, s1_hs, s1_vs, s1_fs, s1_addr},
                model(t, 1, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, SPX, SPY, SPW, SPH,
                      24'h0, 1'b1));
            cmp("s3", t, {s3_x, s3_y, s3_rgb, s3_de, s3_hs, s3_vs, s3_fs, s3_addr},
                model(t, 3, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, SPX, SPY, SPW, SPH,
                      BG3, 1'b0));

            // Hand-computed pins.
            if (t == 2) lit("full_hold_de", 32'(f_de), 0);
            if (t == 3) begin
                lit("full_first_fs", 32'(f_fs), 1);
                lit("full_first_de", 32'(f_de), 1);
            end
            if (t == 4) lit("s3_hold_fs", 32'(s3_fs), 0);
            if (t == 5) lit("s3_first_fs", 32'(s3_fs), 1);
            if (t >= 3) begin
                if (f_x == 11'd799) lit("full_de_799", 32'(f_de), 1);
                if (f_x == 11'd800) lit("full_de_800", 32'(f_de), 0);
                if (f_x == 11'd839) lit("full_hs_839", 32'(f_hs), 0);
                if (f_x == 11'd840) lit("full_hs_840", 32'(f_hs), 1);
                if (f_x == 11'd967) lit("full_hs_967", 32'(f_hs), 1);
                if (f_x == 11'd968) lit("full_hs_968", 32'(f_hs), 0);
            end
            if (t == 0 || f_x == 11'd0) f_hcnt = 0;
            if (f_hs) f_hcnt++;
            if (t >= 3 && f_x == 11'd1000) lit("full_hsync_width", 32'(f_hcnt), 128);

            if (s1_de) begin
                if (s1_x == 11'd3 && s1_y == 11'd2) begin lit("s1_win_0", 32'(s1_rgb), 0); pins++; end
                if (s1_x == 11'd7 && s1_y == 11'd2) begin lit("s1_win_4", 32'(s1_rgb), 4); pins++; end
                if (s1_x == 11'd3 && s1_y == 11'd3) begin lit("s1_win_5", 32'(s1_rgb), 5); pins++; end
                if (s1_x == 11'd7 && s1_y == 11'd5) begin lit("s1_win_19", 32'(s1_rgb), 19); pins++; end
            end
            if (s3_de) begin
                if (s3_x == 11'd3 && s3_y == 11'd2) lit("s3_win_0", 32'(s3_rgb), 0);
                if (s3_x == 11'd7 && s3_y == 11'd5) lit("s3_win_19", 32'(s3_rgb), 19);
                if (s3_x == 11'd2 && s3_y == 11'd2) lit("s3_left_bg", 32'(s3_rgb), 32'hA5A5A5);
                if (s3_x == 11'd8 && s3_y == 11'd2) lit("s3_right_bg", 32'(s3_rgb), 32'hA5A5A5);
                if (s3_x == 11'd3 && s3_y == 11'd6) lit("s3_below_bg", 32'(s3_rgb), 32'hA5A5A5);
            end

            if (t == 0) s1_last_fs = -1;
            if (s1_fs) begin
                if (s1_last_fs >= 0) lit("s1_frame_period", 32'(t - s1_last_fs), 425);
                s1_last_fs = t;
            end
        end
    end

    initial begin
        bit found;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2200) @(negedge clk);

        // Single-cycle reset while u_s1 shows pixel (10,7).
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (s1_de && s1_x == 11'd10 && s1_y == 11'd7) found = 1'b1;
        end
        lit("wait_s1_10_7", 32'(found), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (900) @(negedge clk);

        // Random mid-run resets of random length.
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(450, 30)) @(negedge clk);
            rst = 1'b1;
            repeat ($urandom_range(4, 1)) @(negedge clk);
            rst = 1'b0;
        end
        repeat (1200) @(negedge clk);

        lit("s1_pins_reached", 32'(pins != 0), 1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
